hazard_scoreboard: RTL and testbench

//  Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core. It replaces per-opcode

---
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard D-stage bundle.
// Groups the D-stage instruction descriptor (sources, Tuse, destination, Tnew,
// mult/div flags) with the hazard unit's responses (stall, bubble, forward
// selects, mult/div busy).
//   master : D-stage side, drives the descriptor and receives the responses
//   slave  : hazard scoreboard side
interface hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int TW   = 2,
    parameter int NSTG = 3
);
    localparam int FW = $clog2(NSTG + 1);

    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_rd_rs;
    logic          d_rd_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [AW-1:0] d_wa;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_md_use;
    logic          stall;
    logic          e_flush;
    logic [FW-1:0] fwd_rs;
    logic [FW-1:0] fwd_rt;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_rd_rs, d_rd_rt, d_tuse_rs, d_tuse_rt,
               d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, e_flush, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rd_rs, d_rd_rt, d_tuse_rs, d_tuse_rt,
               d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, e_flush, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard sitting beside the D stage of the MIPS pipeline.
// Tracks {dest reg, remaining Tnew} for the NSTG stages after D, compares them
// with the Tuse of the D instruction and produces stall / E-bubble / forward
// selects. Also owns the HI/LO mult/div busy counter.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous reset, active low
//   hz       : slave side of hazard_scoreboard_if (D descriptor in, hazard
//              responses out; responses are combinational from state + D)
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int NSTG     = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    hazard_scoreboard_if.slave  hz
);
    localparam int FW     = $clog2(NSTG + 1);
    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [TW-1:0] tnew;
    } stg_t;

    stg_t          stg_q [1:NSTG];
    stg_t          stg_d [1:NSTG];
    logic [CW-1:0] md_cnt_q;
    logic [CW-1:0] md_cnt_d;

    logic          match_rs;
    logic          match_rt;
    logic [FW-1:0] k_rs;
    logic [FW-1:0] k_rt;
    logic [TW-1:0] tnew_rs;
    logic [TW-1:0] tnew_rt;
    logic          hz_rs;
    logic          hz_rt;
    logic          md_busy;
    logic          md_stall;
    logic          stall;
    logic          md_accept;

    // Youngest-match search: walk from the oldest stage down to stage 1 so the
    // lowest matching k is the last one written and wins.
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        k_rs     = '0;
        k_rt     = '0;
        tnew_rs  = '0;
        tnew_rt  = '0;
        for (int k = NSTG; k >= 1; k--) begin
            if (stg_q[k].wa != '0 && stg_q[k].wa == hz.d_rs) begin
                match_rs = 1'b1;
                k_rs     = FW'(k);
                tnew_rs  = stg_q[k].tnew;
            end
            if (stg_q[k].wa != '0 && stg_q[k].wa == hz.d_rt) begin
                match_rt = 1'b1;
                k_rt     = FW'(k);
                tnew_rt  = stg_q[k].tnew;
            end
        end
    end

    assign hz_rs    = hz.d_rd_rs & match_rs & (tnew_rs > hz.d_tuse_rs);
    assign hz_rt    = hz.d_rd_rt & match_rt & (tnew_rt > hz.d_tuse_rt);
    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = hz.d_valid & (hz.d_md_start | hz.d_md_use) & md_busy;
    // Held low during reset so the front end is not frozen by stale state.
    assign stall    = reset_n & hz.d_valid & (hz_rs | hz_rt | md_stall);
    assign md_accept = hz.d_valid & hz.d_md_start & ~stall;

    assign hz.stall   = stall;
    assign hz.e_flush = stall;
    // Only the youngest match may forward; if it is not ready yet, an older
    // ready copy holds a stale value and must not be used.
    assign hz.fwd_rs  = (hz.d_rd_rs & match_rs & (tnew_rs == '0)) ? k_rs : '0;
    assign hz.fwd_rt  = (hz.d_rd_rt & match_rt & (tnew_rt == '0)) ? k_rt : '0;
    assign hz.md_busy = md_busy;

    always_comb begin
        stg_d[1] = (stall | ~hz.d_valid) ? '0 : {hz.d_wa, hz.d_tnew};
        for (int k = 2; k <= NSTG; k++) begin
            stg_d[k].wa   = stg_q[k-1].wa;
            stg_d[k].tnew = (stg_q[k-1].tnew == '0) ? '0 : stg_q[k-1].tnew - 1'b1;
        end
    end

    // A start is only accepted when not busy, so the load never overlaps a
    // running count.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_accept) begin
            md_cnt_d = hz.d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 1; k <= NSTG; k++) begin
                stg_q[k] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int k = 1; k <= NSTG; k++) begin
                stg_q[k] <= stg_d[k];
            end
            md_cnt_q <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Each task builds a per-cycle table
// of D-stage stimulus plus hand-derived expected outputs; expected values are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_hazard_scoreboard;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam int NSTG = 3;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] exp_q [$];

    typedef struct {
        bit       rst;
        bit       valid;
        int       rs, rt;
        bit       rd_rs, rd_rt;
        int       tuse_rs, tuse_rt;
        int       wa, tnew;
        bit       md_start, md_div, md_use;
    } d_t;

    hazard_scoreboard_if #(.AW(AW), .TW(TW), .NSTG(NSTG)) hz ();

    hazard_scoreboard #(.AW(AW), .TW(TW), .NSTG(NSTG), .MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic d_t nop();
        d_t d;
        d = '{default: 0};
        return d;
    endfunction

    function automatic d_t prod(int wa, int tnew);
        d_t d = nop();
        d.valid = 1; d.wa = wa; d.tnew = tnew;
        return d;
    endfunction

    function automatic d_t rd(int rs, bit rrs, int trs, int rt, bit rrt, int trt);
        d_t d = nop();
        d.valid = 1; d.rs = rs; d.rd_rs = rrs; d.tuse_rs = trs;
        d.rt = rt; d.rd_rt = rrt; d.tuse_rt = trt;
        return d;
    endfunction

    function automatic d_t md(bit start, bit div, bit use_);
        d_t d = nop();
        d.valid = 1; d.md_start = start; d.md_div = div; d.md_use = use_;
        return d;
    endfunction

    // {stall, e_flush, fwd_rs, fwd_rt, md_busy}
    function automatic logic [6:0] ex(bit st, int fr, int ft, bit mb);
        return {st, st, 2'(fr), 2'(ft), mb};
    endfunction

    function automatic logic [6:0] obs();
        return {hz.stall, hz.e_flush, hz.fwd_rs, hz.fwd_rt, hz.md_busy};
    endfunction

    task automatic drive(d_t d);
        reset_n       = !d.rst;
        hz.d_valid    = d.valid;
        hz.d_rs       = AW'(d.rs);
        hz.d_rt       = AW'(d.rt);
        hz.d_rd_rs    = d.rd_rs;
        hz.d_rd_rt    = d.rd_rt;
        hz.d_tuse_rs  = TW'(d.tuse_rs);
        hz.d_tuse_rt  = TW'(d.tuse_rt);
        hz.d_wa       = AW'(d.wa);
        hz.d_tnew     = TW'(d.tnew);
        hz.d_md_start = d.md_start;
        hz.d_md_div   = d.md_div;
        hz.d_md_use   = d.md_use;
    endtask

    task automatic drain();
        for (int i = 0; i < NSTG + 1; i++) begin
            drive(nop());
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        d_t r;
        r = nop(); r.rst = 1;
        drive(r);
        @(negedge clk);
        st.push_back(r);                         ev.push_back(ex(0, 0, 0, 0));
        r = md(1, 1, 1); r.rd_rs = 1; r.rs = 7; r.rst = 1;
        st.push_back(r);                         ev.push_back(ex(0, 0, 0, 0));
        st.push_back(nop());                     ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fwd_alu();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        st.push_back(prod(5, 1));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(rd(5, 1, 0, 0, 0, 0));      ev.push_back(ex(1, 0, 0, 0));
        st.push_back(rd(5, 1, 0, 0, 0, 0));      ev.push_back(ex(0, 2, 0, 0));
        st.push_back(nop());                     ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fwd_alu c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        d_t u;
        u = rd(9, 1, 1, 8, 1, 1); u.wa = 10; u.tnew = 1;
        st.push_back(prod(8, 2));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(u);                         ev.push_back(ex(1, 0, 0, 0));
        // lw now in stage 2 with Tnew 1: no stall at Tuse 1, not yet forwardable
        st.push_back(u);                         ev.push_back(ex(0, 0, 0, 0));
        st.push_back(rd(0, 0, 0, 8, 1, 0));      ev.push_back(ex(0, 0, 3, 0));
        // lw has left stage 3 and is no longer tracked
        st.push_back(rd(0, 0, 0, 8, 1, 0));      ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_use c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_youngest();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        st.push_back(prod(3, 0));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(prod(3, 0));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(rd(3, 1, 0, 0, 0, 0));      ev.push_back(ex(0, 1, 0, 0));
        st.push_back(prod(3, 0));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(prod(3, 1));                ev.push_back(ex(0, 0, 0, 0));
        st.push_back(rd(3, 1, 0, 0, 0, 0));      ev.push_back(ex(1, 0, 0, 0));
        st.push_back(rd(3, 1, 0, 0, 0, 0));      ev.push_back(ex(0, 2, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL youngest c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_reg();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        st.push_back(prod(0, 2));                ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(rd(0, 1, 0, 0, 1, 0));  ev.push_back(ex(0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL zero_reg c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mdu();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        st.push_back(md(1, 1, 0));               ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            st.push_back(md(0, 0, 1));           ev.push_back(ex(1, 0, 0, 1));
        end
        st.push_back(md(0, 0, 1));               ev.push_back(ex(0, 0, 0, 0));
        st.push_back(md(1, 0, 0));               ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            st.push_back(md(0, 0, 1));           ev.push_back(ex(1, 0, 0, 1));
        end
        st.push_back(md(0, 0, 1));               ev.push_back(ex(0, 0, 0, 0));
        // back-to-back: mult then div, the div waits out the mult
        st.push_back(md(1, 0, 0));               ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            st.push_back(md(1, 1, 0));           ev.push_back(ex(1, 0, 0, 1));
        end
        st.push_back(md(1, 1, 0));               ev.push_back(ex(0, 0, 0, 0));
        st.push_back(nop());                     ev.push_back(ex(0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mdu c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        d_t st[$];
        logic [6:0] ev[$];
        logic [6:0] got, e;
        d_t u;
        drain();
        for (int i = 0; i < 9; i++) begin
            drive(nop());
            @(negedge clk);
        end
        u = md(0, 0, 1); u.rs = 4; u.rd_rs = 1; u.rt = 4; u.rd_rt = 1;
        st.push_back(md(1, 1, 0));               ev.push_back(ex(0, 0, 0, 0));
        st.push_back(prod(4, 2));                ev.push_back(ex(0, 0, 0, 1));
        st.push_back(nop());                     ev.push_back(ex(0, 0, 0, 1));
        u.rst = 1;
        st.push_back(u);                         ev.push_back(ex(0, 0, 0, 1));
        u.rst = 0;
        st.push_back(u);                         ev.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); exp_q.push_back(ev[i]);
            #1; got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid c%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        drive(nop());
        @(negedge clk);
        test_reset();
        drain();
        test_fwd_alu();
        drain();
        test_load_use();
        drain();
        test_youngest();
        drain();
        test_zero_reg();
        drain();
        test_mdu();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
